// File: rtl/game_sequencer_if.sv
// Signal bundle between the dinosaur-game run controller and its surroundings.
//   master: button/collision producer and consumer of the sequencer outputs (testbench, top level)
//   slave : the game_sequencer itself
// Signals:
//   start_btn, jump_btn : debounced button levels
//   collision           : engine level, dino overlaps an obstacle
//   game_tick, jump_req : single-cycle pulses to the game engine
//   run_en, game_over   : state decodes
//   state               : 00 idle, 01 run, 10 dying, 11 over
//   speed, night        : obstacle speed (px/tick) and palette select
//   score, hi_score     : 4-digit BCD
interface game_sequencer_if;
  logic        start_btn;
  logic        jump_btn;
  logic        collision;
  logic        game_tick;
  logic        jump_req;
  logic        run_en;
  logic        game_over;
  logic [1:0]  state;
  logic [3:0]  speed;
  logic        night;
  logic [15:0] score;
  logic [15:0] hi_score;

  modport master (
    output start_btn, jump_btn, collision,
    input  game_tick, jump_req, run_en, game_over, state, speed, night, score, hi_score
  );

  modport slave (
    input  start_btn, jump_btn, collision,
    output game_tick, jump_req, run_en, game_over, state, speed, night, score, hi_score
  );
endinterface

// File: rtl/game_sequencer.sv
// Run controller for the dinosaur game: idle/run/dying/over FSM, game-step tick generation,
// jump-request gating, BCD score and high score, speed ramp and day/night toggle.
// Ports:
//   clk   : system clock
//   rstn  : asynchronous reset, active low
//   gs_io : game_sequencer_if.slave bundle (buttons and collision in; pulses, state, score out)
// All outputs come straight from registers or from decodes of the registered state.
module game_sequencer #(
  parameter int unsigned TICK_DIV     = 1000000,
  parameter int unsigned SPEED_MIN    = 4,
  parameter int unsigned SPEED_MAX    = 12,
  parameter int unsigned SPEED_STEP   = 100,
  parameter int unsigned NIGHT_PERIOD = 700,
  parameter int unsigned DEATH_TICKS  = 32
) (
  input  logic             clk,
  input  logic             rstn,
  game_sequencer_if.slave  gs_io
);

  localparam int unsigned TCW = $clog2(TICK_DIV);
  localparam int unsigned DCW = $clog2(DEATH_TICKS + 1);

  typedef enum logic [1:0] {
    StIdle  = 2'b00,
    StRun   = 2'b01,
    StDying = 2'b10,
    StOver  = 2'b11
  } state_e;

  state_e           state_q, state_d;
  logic             start_q, jump_q, armed_q;
  logic [TCW-1:0]   tick_cnt_q, tick_cnt_d;
  logic [DCW-1:0]   death_q, death_d;
  logic             game_tick_q, game_tick_d;
  logic             jump_req_q, jump_req_d;
  logic [3:0]       speed_q, speed_d;
  logic             night_q, night_d;
  logic [15:0]      score_q, score_d;
  logic [15:0]      hi_q, hi_d;
  logic [13:0]      step_q, step_d;
  logic [13:0]      nite_q, nite_d;

  logic             start_rise, jump_rise;
  logic             counting, wrap, enter_run;
  logic [13:0]      step_inc, nite_inc;

  // One-cycle increment of a 4-digit BCD value, carrying 9 -> 0 into the next digit.
  function automatic logic [15:0] bcd_inc(input logic [15:0] v);
    logic [15:0] r;
    logic        carry;
    r     = v;
    carry = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (carry) begin
        if (r[4*i +: 4] == 4'd9) begin
          r[4*i +: 4] = 4'd0;
        end else begin
          r[4*i +: 4] = r[4*i +: 4] + 4'd1;
          carry       = 1'b0;
        end
      end
    end
    return r;
  endfunction

  // armed_q stays low for the first cycle after reset so that a button held through reset
  // is absorbed into the edge registers instead of producing a rise.
  assign start_rise = armed_q & gs_io.start_btn & ~start_q;
  assign jump_rise  = armed_q & gs_io.jump_btn  & ~jump_q;

  assign counting = (state_q == StRun) || (state_q == StDying);
  assign wrap     = counting && (tick_cnt_q == TCW'(TICK_DIV - 1));
  assign step_inc = step_q + 14'd1;
  assign nite_inc = nite_q + 14'd1;

  always_comb begin
    state_d     = state_q;
    tick_cnt_d  = '0;
    death_d     = death_q;
    game_tick_d = 1'b0;
    jump_req_d  = 1'b0;
    speed_d     = speed_q;
    night_d     = night_q;
    score_d     = score_q;
    hi_d        = hi_q;
    step_d      = step_q;
    nite_d      = nite_q;
    enter_run   = 1'b0;

    if (counting) begin
      tick_cnt_d = wrap ? '0 : tick_cnt_q + TCW'(1);
    end

    unique case (state_q)
      StIdle: begin
        if (start_rise || jump_rise) begin
          enter_run = 1'b1;
        end
      end
      StRun: begin
        if (gs_io.collision) begin
          // Collision wins over tick and jump in the same cycle.
          state_d = StDying;
          death_d = '0;
          // Valid BCD digits sort like binary nibbles, so an unsigned compare is MSD-first.
          if (score_q > hi_q) begin
            hi_d = score_q;
          end
        end else begin
          if (wrap) begin
            game_tick_d = 1'b1;
            if (score_q != 16'h9999) begin
              score_d = bcd_inc(score_q);
            end
            if (step_inc == 14'(SPEED_STEP)) begin
              step_d = '0;
              if (speed_q < 4'(SPEED_MAX)) begin
                speed_d = speed_q + 4'd1;
              end
            end else begin
              step_d = step_inc;
            end
            if (nite_inc == 14'(NIGHT_PERIOD)) begin
              nite_d  = '0;
              night_d = ~night_q;
            end else begin
              nite_d = nite_inc;
            end
          end
          if (jump_rise) begin
            jump_req_d = 1'b1;
          end
        end
      end
      StDying: begin
        if (wrap) begin
          if (death_q == DCW'(DEATH_TICKS - 1)) begin
            state_d = StOver;
          end else begin
            death_d = death_q + DCW'(1);
          end
        end
      end
      StOver: begin
        if (start_rise) begin
          enter_run = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase

    if (enter_run) begin
      state_d    = StRun;
      tick_cnt_d = '0;
      score_d    = '0;
      speed_d    = 4'(SPEED_MIN);
      night_d    = 1'b0;
      step_d     = '0;
      nite_d     = '0;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= StIdle;
      start_q     <= 1'b0;
      jump_q      <= 1'b0;
      armed_q     <= 1'b0;
      tick_cnt_q  <= '0;
      death_q     <= '0;
      game_tick_q <= 1'b0;
      jump_req_q  <= 1'b0;
      speed_q     <= 4'(SPEED_MIN);
      night_q     <= 1'b0;
      score_q     <= '0;
      hi_q        <= '0;
      step_q      <= '0;
      nite_q      <= '0;
    end else begin
      state_q     <= state_d;
      start_q     <= gs_io.start_btn;
      jump_q      <= gs_io.jump_btn;
      armed_q     <= 1'b1;
      tick_cnt_q  <= tick_cnt_d;
      death_q     <= death_d;
      game_tick_q <= game_tick_d;
      jump_req_q  <= jump_req_d;
      speed_q     <= speed_d;
      night_q     <= night_d;
      score_q     <= score_d;
      hi_q        <= hi_d;
      step_q      <= step_d;
      nite_q      <= nite_d;
    end
  end

  assign gs_io.game_tick = game_tick_q;
  assign gs_io.jump_req  = jump_req_q;
  assign gs_io.run_en    = (state_q == StRun);
  assign gs_io.game_over = state_q[1];
  assign gs_io.state     = state_q;
  assign gs_io.speed     = speed_q;
  assign gs_io.night     = night_q;
  assign gs_io.score     = score_q;
  assign gs_io.hi_score  = hi_q;

endmodule

// File: tb/tb_game_sequencer.sv
// Self-checking bench for game_sequencer: constant vector table, directed multi-cycle
// sequences and random stimulus, all compared against a score/tick-count reference model.
module tb_game_sequencer;

  localparam int unsigned TD    = 4;
  localparam int unsigned SMIN  = 4;
  localparam int unsigned SMAX  = 6;
  localparam int unsigned SSTEP = 5;
  localparam int unsigned NP    = 10;
  localparam int unsigned DT    = 3;

  logic clk = 1'b0;
  logic rstn;
  always #5 clk = ~clk;

  game_sequencer_if gs_if ();

  game_sequencer #(
    .TICK_DIV    (TD),
    .SPEED_MIN   (SMIN),
    .SPEED_MAX   (SMAX),
    .SPEED_STEP  (SSTEP),
    .NIGHT_PERIOD(NP),
    .DEATH_TICKS (DT)
  ) dut (
    .clk  (clk),
    .rstn (rstn),
    .gs_io(gs_if)
  );

  int n_vec = 0;
  int n_err = 0;

  // Reference model: game progress is just the number of ticks taken in the current run.
  int m_st, m_cnt, m_ticks, m_death, m_hi;
  bit m_tick, m_jreq, m_prev_s, m_prev_j, m_armed;

  typedef struct {
    logic        s, j, c;
    logic [1:0]  st;
    logic        tick, jreq;
    logic [15:0] score;
  } vec_t;
  vec_t tbl[14];

  function automatic logic [15:0] to_bcd(input int v);
    return {4'(v / 1000 % 10), 4'(v / 100 % 10), 4'(v / 10 % 10), 4'(v % 10)};
  endfunction

  function int m_cap();
    return (m_ticks > 9999) ? 9999 : m_ticks;
  endfunction

  function logic [3:0] m_speed();
    int s;
    s = SMIN + m_ticks / SSTEP;
    if (s > SMAX) s = SMAX;
    return 4'(s);
  endfunction

  function logic [42:0] m_exp();
    return {2'(m_st), m_tick, m_jreq, (m_st == 1), (m_st >= 2), m_speed(),
            1'((m_ticks / NP) % 2), to_bcd(m_cap()), to_bcd(m_hi)};
  endfunction

  function logic [42:0] dut_bundle();
    return {gs_if.state, gs_if.game_tick, gs_if.jump_req, gs_if.run_en, gs_if.game_over,
            gs_if.speed, gs_if.night, gs_if.score, gs_if.hi_score};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  task automatic model_reset();
    m_st = 0; m_cnt = 0; m_ticks = 0; m_death = 0; m_hi = 0;
    m_tick = 0; m_jreq = 0; m_prev_s = 0; m_prev_j = 0; m_armed = 0;
  endtask

  task automatic model_step(input bit s, input bit j, input bit c);
    bit sr, jr, cnt_on, wrap;
    int ncnt;
    sr     = m_armed & s & ~m_prev_s;
    jr     = m_armed & j & ~m_prev_j;
    cnt_on = (m_st == 1) || (m_st == 2);
    wrap   = cnt_on && (m_cnt == TD - 1);
    ncnt   = cnt_on ? (m_cnt + 1) % TD : 0;
    m_tick = 0;
    m_jreq = 0;
    case (m_st)
      0: if (sr || jr) begin m_st = 1; m_ticks = 0; ncnt = 0; end
      1: begin
        if (c) begin
          m_st = 2;
          m_death = 0;
          if (m_cap() > m_hi) m_hi = m_cap();
        end else begin
          if (wrap) begin m_ticks++; m_tick = 1; end
          if (jr) m_jreq = 1;
        end
      end
      2: if (wrap) begin m_death++; if (m_death == DT) m_st = 3; end
      default: if (sr) begin m_st = 1; m_ticks = 0; ncnt = 0; end
    endcase
    m_cnt    = ncnt;
    m_prev_s = s;
    m_prev_j = j;
    m_armed  = 1;
  endtask

  // Called at a negedge: drive, clock once, compare at the following negedge.
  task automatic cycle(input bit s, input bit j, input bit c);
    gs_if.start_btn = s;
    gs_if.jump_btn  = j;
    gs_if.collision = c;
    model_step(s, j, c);
    @(posedge clk);
    @(negedge clk);
    chk("model", 64'(dut_bundle()), 64'(m_exp()));
  endtask

  task automatic do_reset(input bit hold_s);
    gs_if.start_btn = hold_s;
    gs_if.jump_btn  = 1'b0;
    gs_if.collision = 1'b0;
    rstn = 1'b0;
    #1;
    model_reset();
    chk("reset_async", 64'(dut_bundle()), 64'(m_exp()));
    chk("reset_speed", 64'(gs_if.speed), 64'(SMIN));
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    rstn = 1'b1;
  endtask

  initial begin
    int k;
    bit rs, rj, rc;
    tbl[0]  = '{1'b1, 1'b1, 1'b0, 2'd1, 1'b0, 1'b0, 16'h0000};
    tbl[1]  = '{1'b0, 1'b0, 1'b0, 2'd1, 1'b0, 1'b0, 16'h0000};
    tbl[2]  = '{1'b0, 1'b0, 1'b0, 2'd1, 1'b0, 1'b0, 16'h0000};
    tbl[3]  = '{1'b0, 1'b0, 1'b0, 2'd1, 1'b0, 1'b0, 16'h0000};
    tbl[4]  = '{1'b0, 1'b0, 1'b0, 2'd1, 1'b1, 1'b0, 16'h0001};
    tbl[5]  = '{1'b0, 1'b1, 1'b0, 2'd1, 1'b0, 1'b1, 16'h0001};
    tbl[6]  = '{1'b0, 1'b1, 1'b0, 2'd1, 1'b0, 1'b0, 16'h0001};
    tbl[7]  = '{1'b0, 1'b0, 1'b0, 2'd1, 1'b0, 1'b0, 16'h0001};
    tbl[8]  = '{1'b0, 1'b0, 1'b0, 2'd1, 1'b1, 1'b0, 16'h0002};
    tbl[9]  = '{1'b0, 1'b1, 1'b0, 2'd1, 1'b0, 1'b1, 16'h0002};
    tbl[10] = '{1'b0, 1'b0, 1'b0, 2'd1, 1'b0, 1'b0, 16'h0002};
    tbl[11] = '{1'b0, 1'b1, 1'b0, 2'd1, 1'b0, 1'b1, 16'h0002};
    tbl[12] = '{1'b0, 1'b0, 1'b0, 2'd1, 1'b1, 1'b0, 16'h0003};
    tbl[13] = '{1'b0, 1'b1, 1'b1, 2'd2, 1'b0, 1'b0, 16'h0003};

    rstn            = 1'b1;
    gs_if.start_btn = 1'b0;
    gs_if.jump_btn  = 1'b0;
    gs_if.collision = 1'b0;
    @(negedge clk);

    // Start, tick cadence, jump pulses, jump+collision.
    do_reset(1'b0);
    cycle(1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 14; i++) begin
      cycle(tbl[i].s, tbl[i].j, tbl[i].c);
      chk("tbl_state", 64'(gs_if.state), 64'(tbl[i].st));
      chk("tbl_tick", 64'(gs_if.game_tick), 64'(tbl[i].tick));
      chk("tbl_jreq", 64'(gs_if.jump_req), 64'(tbl[i].jreq));
      chk("tbl_score", 64'(gs_if.score), 64'(tbl[i].score));
    end
    chk("tbl_hi", 64'(gs_if.hi_score), 64'h0003);

    // Collision on the wrap cycle, dying duration, over-state buttons.
    do_reset(1'b0);
    cycle(1'b0, 1'b0, 1'b0);
    cycle(1'b1, 1'b0, 1'b0);
    repeat (7) cycle(1'b0, 1'b0, 1'b0);
    cycle(1'b0, 1'b0, 1'b1);
    chk("coll_wrap_state", 64'(gs_if.state), 64'd2);
    chk("coll_wrap_score", 64'(gs_if.score), 64'h0001);
    chk("coll_wrap_tick", 64'(gs_if.game_tick), 64'd0);
    repeat (11) cycle(1'b0, 1'b0, 1'b0);
    chk("dying_11", 64'(gs_if.state), 64'd2);
    cycle(1'b0, 1'b0, 1'b0);
    chk("dying_12", 64'(gs_if.state), 64'd3);
    chk("hi_after_death", 64'(gs_if.hi_score), 64'h0001);
    cycle(1'b0, 1'b1, 1'b0);
    cycle(1'b0, 1'b0, 1'b0);
    chk("over_jump", 64'(gs_if.state), 64'd3);
    cycle(1'b1, 1'b0, 1'b0);
    chk("restart_state", 64'(gs_if.state), 64'd1);
    chk("restart_score", 64'(gs_if.score), 64'h0000);
    chk("restart_speed", 64'(gs_if.speed), 64'd4);
    chk("restart_hi", 64'(gs_if.hi_score), 64'h0001);

    // Speed ramp and night toggle over 15 ticks.
    for (k = 1; k <= 15; k++) begin
      repeat (4) cycle(1'b0, 1'b0, 1'b0);
      chk("ramp_speed", 64'(gs_if.speed), (k < 5) ? 64'd4 : (k < 10) ? 64'd5 : 64'd6);
      chk("ramp_night", 64'(gs_if.night), (k >= 10) ? 64'd1 : 64'd0);
    end

    // Asynchronous reset mid-run, start held through reset.
    do_reset(1'b1);
    repeat (3) cycle(1'b1, 1'b0, 1'b0);
    chk("held_start", 64'(gs_if.state), 64'd0);
    cycle(1'b0, 1'b0, 1'b0);
    cycle(1'b1, 1'b0, 1'b0);
    chk("start_after_held", 64'(gs_if.state), 64'd1);

    // Long run: BCD carries and saturation at 9999.
    for (int t = 1; t <= 10003; t++) begin
      repeat (4) cycle(1'b0, 1'b0, 1'b0);
      if (t == 9)    chk("bcd_0009", 64'(gs_if.score), 64'h0009);
      if (t == 10)   chk("bcd_0010", 64'(gs_if.score), 64'h0010);
      if (t == 99)   chk("bcd_0099", 64'(gs_if.score), 64'h0099);
      if (t == 100)  chk("bcd_0100", 64'(gs_if.score), 64'h0100);
      if (t == 9998) chk("bcd_9998", 64'(gs_if.score), 64'h9998);
      if (t >= 9999) chk("bcd_hold", 64'(gs_if.score), 64'h9999);
    end

    // Random traffic including occasional resets.
    do_reset(1'b0);
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 999) == 0) do_reset(1'($urandom_range(0, 1)));
      rs = ($urandom_range(0, 11) == 0);
      rj = ($urandom_range(0, 3) == 0);
      rc = ($urandom_range(0, 59) == 0);
      cycle(rs, rj, rc);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
